// File: rtl/flt2fix_batch_ctrl.sv
// flt2fix_batch_ctrl
// Batch sequencer that walks Count half-precision floats in byte-wide data
// memory, hands each one to a shared float-to-fixed converter over a
// req/ack handshake and writes the 8.8 result back as a byte pair.
// Every output is a flop loaded from the state being entered, so the
// address and strobes are already valid in the first cycle of each state.
module flt2fix_batch_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcBase,
  input  logic [ADDR_W-1:0] DstBase,
  input  logic [CNT_W-1:0]  Count,
  output logic              Return,
  output logic              Busy,
  output logic              Err,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [7:0]        MemRdData,
  output logic              MemWrEn,
  output logic [7:0]        MemWrData,
  output logic              CvtReq,
  output logic [15:0]       CvtFlt,
  input  logic              CvtAck,
  input  logic [15:0]       CvtFix
);

  localparam int unsigned       TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_TWO = ADDR_W'(2);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [15:0]       TRAP_FIX = 16'h8000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_REQ   = 3'd3,
    S_WAIT  = 3'd4,
    S_WR_LO = 3'd5,
    S_WR_HI = 3'd6,
    S_DONE  = 3'd7
  } state_e;

  state_e state_q, state_d;

  // Datapath registers: running element pointers, element index, timeout
  // counter, converter operand and result.
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [15:0]       res_q, res_d;
  logic [15:0]       flt_q, flt_d;
  logic              err_q, err_d;

  // Output registers.
  logic              ret_q, ret_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              req_q, req_d;

  logic [CNT_W-1:0]  idx_inc;
  logic              start_ok;
  logic              to_hit;

  assign idx_inc  = idx_q + CNT_ONE;
  assign start_ok = Start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign to_hit   = (to_cnt_q == TO_LAST);

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: Start is only honoured in IDLE/DONE, ack only in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d = (Count == CNT_ZERO) ? S_DONE : S_RD_LO;
        end else begin
          state_d = state_q;
        end
      end
      S_RD_LO: state_d = S_RD_HI;
      S_RD_HI: state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (CvtAck || to_hit) begin
          state_d = S_WR_LO;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WR_LO: state_d = S_WR_HI;
      S_WR_HI: begin
        if (idx_inc == cnt_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD_LO;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture on start, assemble the operand, run the
  // timeout counter and advance both pointers by one element after WR_HI.
  always_comb begin
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    to_cnt_d  = to_cnt_q;
    res_d     = res_q;
    flt_d     = flt_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          src_ptr_d = SrcBase;
          dst_ptr_d = DstBase;
          cnt_d     = Count;
          idx_d     = CNT_ZERO;
          err_d     = 1'b0;
        end else begin
          err_d     = err_q;
        end
      end
      S_RD_LO: flt_d[7:0]  = MemRdData;
      S_RD_HI: flt_d[15:8] = MemRdData;
      S_REQ:   to_cnt_d    = {TO_W{1'b0}};
      S_WAIT: begin
        if (CvtAck) begin
          res_d = CvtFix;
        end else if (to_hit) begin
          res_d = TRAP_FIX;
          err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end
      S_WR_HI: begin
        idx_d     = idx_inc;
        src_ptr_d = src_ptr_q + ADDR_TWO;
        dst_ptr_d = dst_ptr_q + ADDR_TWO;
      end
      default: begin
        res_d = res_q;
      end
    endcase
  end

  // Output next values, decoded from the state being entered so the
  // registered outputs line up with that state's cycle.
  always_comb begin
    ret_d     = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    req_d     = 1'b0;
    case (state_d)
      S_RD_LO: addr_d = src_ptr_d;
      S_RD_HI: addr_d = src_ptr_d + ADDR_ONE;
      S_REQ:   req_d  = 1'b1;
      S_WR_LO: begin
        addr_d    = dst_ptr_d;
        wr_en_d   = 1'b1;
        wr_data_d = res_d[7:0];
      end
      S_WR_HI: begin
        addr_d    = dst_ptr_d + ADDR_ONE;
        wr_en_d   = 1'b1;
        wr_data_d = res_d[15:8];
      end
      default: begin
        addr_d = addr_q;
      end
    endcase
  end

  // Datapath and output registers; reset clears every output immediately.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      src_ptr_q <= {ADDR_W{1'b0}};
      dst_ptr_q <= {ADDR_W{1'b0}};
      cnt_q     <= CNT_ZERO;
      idx_q     <= CNT_ZERO;
      to_cnt_q  <= {TO_W{1'b0}};
      res_q     <= 16'h0000;
      flt_q     <= 16'h0000;
      err_q     <= 1'b0;
      ret_q     <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'h00;
      req_q     <= 1'b0;
    end else begin
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      to_cnt_q  <= to_cnt_d;
      res_q     <= res_d;
      flt_q     <= flt_d;
      err_q     <= err_d;
      ret_q     <= ret_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      req_q     <= req_d;
    end
  end

  assign Return    = ret_q;
  assign Busy      = busy_q;
  assign Err       = err_q;
  assign MemAddr   = addr_q;
  assign MemWrEn   = wr_en_q;
  assign MemWrData = wr_data_q;
  assign CvtReq    = req_q;
  assign CvtFlt    = flt_q;

endmodule

// File: tb/tb_flt2fix_batch_ctrl.sv
// Self-checking bench for flt2fix_batch_ctrl: byte memory and converter
// models plus a batch-level reference that predicts results and cycle counts.
module tb_flt2fix_batch_ctrl;

  localparam int TO    = 64;
  localparam int BOUND = 2000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [7:0]  SrcBase, DstBase, Count;
  logic        Return, Busy, Err, MemWrEn, CvtReq, CvtAck;
  logic [7:0]  MemAddr, MemRdData, MemWrData;
  logic [15:0] CvtFlt, CvtFix;

  // Memory: init_mem is written by tests, wr_mem by the DUT; a generation
  // stamp selects which copy is current, so each array has one writer.
  logic [7:0] init_mem [256];
  logic [7:0] wr_mem   [256];
  int         wr_gen   [256] = '{default: -1};
  int         gen = 0;

  // Converter model controls.
  int          ack_k = 1;
  bit          tbl_mode = 1'b0;
  bit          spur = 1'b0;
  logic [15:0] tbl_map [logic [15:0]];
  logic [15:0] req_log [$];
  logic [15:0] cur_flt;
  int          cd;

  int req_cnt = 0, we_cnt = 0, req_dbl = 0;
  bit prev_req = 1'b0;
  int checks = 0, errors = 0;

  logic [15:0] exp_flt [$];
  logic [15:0] exp_res [$];

  flt2fix_batch_ctrl #(.ADDR_W(8), .CNT_W(8), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .SrcBase(SrcBase), .DstBase(DstBase),
    .Count(Count), .Return(Return), .Busy(Busy), .Err(Err), .MemAddr(MemAddr),
    .MemRdData(MemRdData), .MemWrEn(MemWrEn), .MemWrData(MemWrData),
    .CvtReq(CvtReq), .CvtFlt(CvtFlt), .CvtAck(CvtAck), .CvtFix(CvtFix)
  );

  always #5 Clk = ~Clk;

  assign MemRdData = (wr_gen[MemAddr] == gen) ? wr_mem[MemAddr] : init_mem[MemAddr];

  function automatic logic [7:0] rd(input logic [7:0] a);
    return (wr_gen[a] == gen) ? wr_mem[a] : init_mem[a];
  endfunction

  // Opaque converter behaviour: table lookup for directed cases, else a hash.
  function automatic logic [15:0] conv_ref(input logic [15:0] f);
    if (tbl_mode && tbl_map.exists(f)) return tbl_map[f];
    return f * 16'd3 + 16'h1234;
  endfunction

  // Memory write port.
  always @(posedge Clk) begin
    if (MemWrEn === 1'b1) begin
      wr_mem[MemAddr] <= MemWrData;
      wr_gen[MemAddr] <= gen;
    end
  end

  // Activity monitor.
  always @(negedge Clk) begin
    if (CvtReq === 1'b1) req_cnt <= req_cnt + 1;
    if (MemWrEn === 1'b1) we_cnt <= we_cnt + 1;
    if (CvtReq === 1'b1 && prev_req) req_dbl <= req_dbl + 1;
    prev_req <= (CvtReq === 1'b1);
  end

  // Converter: acks in the ack_k-th WAIT cycle after a request (0 = never).
  initial begin
    CvtAck = 1'b0; CvtFix = 16'h0000; cd = 0; cur_flt = 16'h0000;
    forever begin
      @(posedge Clk); #1;
      CvtAck = 1'b0;
      if (spur) begin CvtAck = 1'b1; CvtFix = 16'hBAD0; end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin CvtAck = 1'b1; CvtFix = conv_ref(cur_flt); end
      end
      if (CvtReq === 1'b1) begin
        req_log.push_back(CvtFlt);
        cur_flt = CvtFlt;
        cd = ack_k;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic new_mem();
    gen++;
    for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
  endtask

  // Reference: floats read from the current memory, results from the
  // converter behaviour (or the trap value when the converter never answers).
  task automatic build_exp(input logic [7:0] src, input int n, input bit to_mode);
    logic [7:0]  a;
    logic [15:0] f;
    exp_flt.delete();
    exp_res.delete();
    for (int i = 0; i < n; i++) begin
      a = src + 8'(2 * i);
      f = {rd(a + 8'd1), rd(a)};
      exp_flt.push_back(f);
      exp_res.push_back(to_mode ? 16'h8000 : conv_ref(f));
    end
  endtask

  // Start a batch in cycle 0 and return the cycle where Return is seen.
  // Optional injections: Start pulse in cycle inj_c, spurious ack in cycle
  // spur_c+1, reset drop in cycle rst_c (returns -2 right after the drop).
  task automatic run_batch(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] n,
                           input int inj_c, input int spur_c, input int rst_c, output int ret);
    @(negedge Clk);
    SrcBase = src; DstBase = dst; Count = n; Start = 1'b1;
    ret = -1;
    for (int c = 1; c <= BOUND; c++) begin
      @(negedge Clk);
      Start = (c == inj_c);
      if (c == inj_c) begin SrcBase = 8'hA0; DstBase = 8'h00; Count = 8'd5; end
      spur = (c == spur_c);
      if (c == rst_c) begin Reset = 1'b0; ret = -2; break; end
      if (Return === 1'b1) begin ret = c; break; end
    end
    spur = 1'b0;
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Start = 1'b0; SrcBase = 8'h00; DstBase = 8'h00; Count = 8'h00;
    repeat (3) @(negedge Clk);
    checks += 8;
    if (Return !== 1'b0)     begin errors++; $display("FAIL reset_Return: got %b expected 0", Return); end
    if (Busy !== 1'b0)       begin errors++; $display("FAIL reset_Busy: got %b expected 0", Busy); end
    if (Err !== 1'b0)        begin errors++; $display("FAIL reset_Err: got %b expected 0", Err); end
    if (MemAddr !== 8'h00)   begin errors++; $display("FAIL reset_MemAddr: got %h expected 00", MemAddr); end
    if (MemWrEn !== 1'b0)    begin errors++; $display("FAIL reset_MemWrEn: got %b expected 0", MemWrEn); end
    if (MemWrData !== 8'h00) begin errors++; $display("FAIL reset_MemWrData: got %h expected 00", MemWrData); end
    if (CvtReq !== 1'b0)     begin errors++; $display("FAIL reset_CvtReq: got %b expected 0", CvtReq); end
    if (CvtFlt !== 16'h0)    begin errors++; $display("FAIL reset_CvtFlt: got %h expected 0000", CvtFlt); end
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_single();
    int ret;
    new_mem();
    init_mem[4] = 8'h00; init_mem[5] = 8'h3C;
    tbl_mode = 1'b1; tbl_map[16'h3C00] = 16'h0100; ack_k = 1;
    run_batch(8'd4, 8'd6, 8'd1, 0, 0, 0, ret);
    checks += 4;
    if (ret !== 7)          begin errors++; $display("FAIL single_return_cycle: got %0d expected 7", ret); end
    if (rd(8'd6) !== 8'h00) begin errors++; $display("FAIL single_lo: got %h expected 00", rd(8'd6)); end
    if (rd(8'd7) !== 8'h01) begin errors++; $display("FAIL single_hi: got %h expected 01", rd(8'd7)); end
    if (Err !== 1'b0)       begin errors++; $display("FAIL single_err: got %b expected 0", Err); end
  endtask

  task automatic test_wrap();
    int ret, base;
    logic [15:0] flts [3] = '{16'h3E00, 16'hC000, 16'h7BC0};
    logic [7:0]  outb [6] = '{8'h80, 8'h01, 8'h00, 8'hFE, 8'hFF, 8'h7F};
    new_mem();
    init_mem[8'hFE] = 8'h00; init_mem[8'hFF] = 8'h3E;
    init_mem[8'h00] = 8'h00; init_mem[8'h01] = 8'hC0;
    init_mem[8'h02] = 8'hC0; init_mem[8'h03] = 8'h7B;
    tbl_mode = 1'b1;
    tbl_map[16'h3E00] = 16'h0180; tbl_map[16'hC000] = 16'hFE00; tbl_map[16'h7BC0] = 16'h7FFF;
    ack_k = 3;
    base = req_log.size();
    run_batch(8'hFE, 8'h40, 8'd3, 0, 0, 0, ret);
    checks++;
    if (ret !== 25) begin errors++; $display("FAIL wrap_return_cycle: got %0d expected 25", ret); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_log[base + i] !== flts[i]) begin
        errors++; $display("FAIL wrap_float%0d: got %h expected %h", i, req_log[base + i], flts[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rd(8'h40 + 8'(i)) !== outb[i]) begin
        errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, rd(8'h40 + 8'(i)), outb[i]);
      end
    end
    tbl_mode = 1'b0;
  endtask

  task automatic test_count_zero();
    int ret, r0, w0;
    r0 = req_cnt; w0 = we_cnt;
    run_batch(8'h10, 8'h20, 8'd0, 0, 0, 0, ret);
    @(posedge Clk); #1;
    checks += 3;
    if (ret !== 1)        begin errors++; $display("FAIL zero_return_cycle: got %0d expected 1", ret); end
    if (req_cnt != r0)    begin errors++; $display("FAIL zero_req: got %0d requests expected 0", req_cnt - r0); end
    if (we_cnt != w0)     begin errors++; $display("FAIL zero_wr: got %0d writes expected 0", we_cnt - w0); end
  endtask

  task automatic test_timeout();
    int ret, w0;
    logic [15:0] got;
    new_mem();
    ack_k = 0;
    w0 = we_cnt;
    run_batch(8'h10, 8'h20, 8'd1, 0, 0, 0, ret);
    got = {rd(8'h21), rd(8'h20)};
    checks += 4;
    if (ret !== 6 + TO)     begin errors++; $display("FAIL timeout_return_cycle: got %0d expected %0d", ret, 6 + TO); end
    if (Err !== 1'b1)       begin errors++; $display("FAIL timeout_err: got %b expected 1", Err); end
    if (got !== 16'h8000)   begin errors++; $display("FAIL timeout_value: got %h expected 8000", got); end
    if (we_cnt - w0 != 2)   begin errors++; $display("FAIL timeout_writes: got %0d expected 2", we_cnt - w0); end
    ack_k = 2;
    build_exp(8'h10, 1, 1'b0);
    run_batch(8'h10, 8'h20, 8'd1, 0, 0, 0, ret);
    got = {rd(8'h21), rd(8'h20)};
    checks += 3;
    if (ret !== 8)          begin errors++; $display("FAIL restart_return_cycle: got %0d expected 8", ret); end
    if (Err !== 1'b0)       begin errors++; $display("FAIL restart_err_cleared: got %b expected 0", Err); end
    if (got !== exp_res[0]) begin errors++; $display("FAIL restart_value: got %h expected %h", got, exp_res[0]); end
  endtask

  task automatic test_busy_ignore();
    int ret, r0;
    logic [15:0] got;
    new_mem();
    ack_k = 2;
    build_exp(8'h30, 2, 1'b0);
    r0 = req_cnt;
    run_batch(8'h30, 8'h50, 8'd2, 4, 1, 0, ret);
    checks += 3;
    if (ret !== 15)       begin errors++; $display("FAIL busy_return_cycle: got %0d expected 15", ret); end
    if (req_cnt - r0 != 2) begin errors++; $display("FAIL busy_req_count: got %0d expected 2", req_cnt - r0); end
    if (Err !== 1'b0)     begin errors++; $display("FAIL busy_err: got %b expected 0", Err); end
    for (int i = 0; i < 2; i++) begin
      got = {rd(8'h51 + 8'(2 * i)), rd(8'h50 + 8'(2 * i))};
      checks++;
      if (got !== exp_res[i]) begin errors++; $display("FAIL busy_result%0d: got %h expected %h", i, got, exp_res[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int ret;
    logic [15:0] got;
    new_mem();
    init_mem[8'h60] = 8'h11; init_mem[8'h61] = 8'h22;
    init_mem[8'h62] = 8'h33; init_mem[8'h63] = 8'h44;
    for (int i = 0; i < 4; i++) init_mem[8'h70 + 8'(i)] = 8'hEE;
    ack_k = 1;
    build_exp(8'h60, 2, 1'b0);
    run_batch(8'h60, 8'h70, 8'd2, 0, 0, 11, ret);
    #1;
    checks += 8;
    if (Return !== 1'b0)     begin errors++; $display("FAIL mid_Return: got %b expected 0", Return); end
    if (Busy !== 1'b0)       begin errors++; $display("FAIL mid_Busy: got %b expected 0", Busy); end
    if (Err !== 1'b0)        begin errors++; $display("FAIL mid_Err: got %b expected 0", Err); end
    if (MemAddr !== 8'h00)   begin errors++; $display("FAIL mid_MemAddr: got %h expected 00", MemAddr); end
    if (MemWrEn !== 1'b0)    begin errors++; $display("FAIL mid_MemWrEn: got %b expected 0", MemWrEn); end
    if (MemWrData !== 8'h00) begin errors++; $display("FAIL mid_MemWrData: got %h expected 00", MemWrData); end
    if (CvtReq !== 1'b0)     begin errors++; $display("FAIL mid_CvtReq: got %b expected 0", CvtReq); end
    if (CvtFlt !== 16'h0)    begin errors++; $display("FAIL mid_CvtFlt: got %h expected 0000", CvtFlt); end
    @(negedge Clk);
    Reset = 1'b1;
    got = {rd(8'h71), rd(8'h70)};
    checks += 3;
    if (got !== exp_res[0])  begin errors++; $display("FAIL mid_elem0: got %h expected %h", got, exp_res[0]); end
    if (rd(8'h73) !== 8'hEE) begin errors++; $display("FAIL mid_elem1_hi_written: got %h expected ee", rd(8'h73)); end
    if (rd(8'h72) !== 8'hEE) begin errors++; $display("FAIL mid_elem1_lo_written: got %h expected ee", rd(8'h72)); end
    run_batch(8'h60, 8'h70, 8'd2, 0, 0, 0, ret);
    checks++;
    if (ret !== 13) begin errors++; $display("FAIL mid_restart_cycle: got %0d expected 13", ret); end
    for (int i = 0; i < 2; i++) begin
      got = {rd(8'h71 + 8'(2 * i)), rd(8'h70 + 8'(2 * i))};
      checks++;
      if (got !== exp_res[i]) begin errors++; $display("FAIL mid_restart%0d: got %h expected %h", i, got, exp_res[i]); end
    end
  endtask

  task automatic test_random();
    int ret, n, k, r0, w0, base;
    logic [7:0]  src, dst;
    logic [15:0] got;
    for (int t = 0; t < 5; t++) begin
      n   = $urandom_range(1, 8);
      k   = $urandom_range(1, 5);
      src = 8'($urandom);
      dst = src + 8'(2 * n) + 8'($urandom_range(0, 50));
      new_mem();
      ack_k = k;
      build_exp(src, n, 1'b0);
      r0 = req_cnt; w0 = we_cnt; base = req_log.size();
      run_batch(src, dst, 8'(n), 0, 0, 0, ret);
      checks += 4;
      if (ret !== 1 + n * (5 + k)) begin errors++; $display("FAIL rand%0d_cycle: got %0d expected %0d", t, ret, 1 + n * (5 + k)); end
      if (req_cnt - r0 != n)      begin errors++; $display("FAIL rand%0d_reqs: got %0d expected %0d", t, req_cnt - r0, n); end
      if (we_cnt - w0 != 2 * n)   begin errors++; $display("FAIL rand%0d_writes: got %0d expected %0d", t, we_cnt - w0, 2 * n); end
      if (Err !== 1'b0)           begin errors++; $display("FAIL rand%0d_err: got %b expected 0", t, Err); end
      for (int i = 0; i < n; i++) begin
        got = {rd(dst + 8'(2 * i + 1)), rd(dst + 8'(2 * i))};
        checks += 2;
        if (req_log[base + i] !== exp_flt[i]) begin
          errors++; $display("FAIL rand%0d_float%0d: got %h expected %h", t, i, req_log[base + i], exp_flt[i]);
        end
        if (got !== exp_res[i]) begin
          errors++; $display("FAIL rand%0d_result%0d: got %h expected %h", t, i, got, exp_res[i]);
        end
      end
    end
    checks++;
    if (req_dbl != 0) begin errors++; $display("FAIL back_to_back_req: got %0d expected 0", req_dbl); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_count_zero();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
